// File: rtl/cpu_controller_pkg.sv
// Shared definitions for the cpu_controller slice: widths, opcodes, FSM states
// and the instruction field layout with a decode helper.
package cpu_controller_pkg;

  localparam int unsigned DATA_W     = 8;
  localparam int unsigned INSTR_W    = 8;
  localparam int unsigned ADDR_W     = 8;
  localparam int unsigned NREGS      = 4;
  localparam int unsigned RIDX_W     = 2;
  localparam int unsigned DMEM_DEPTH = 4;
  localparam int unsigned IMM_W      = 4;

  // Instruction field bit positions
  localparam int unsigned OP_MSB  = 7;
  localparam int unsigned OP_LSB  = 6;
  localparam int unsigned A_MSB   = 5;
  localparam int unsigned A_LSB   = 4;
  localparam int unsigned R_MSB   = 3;
  localparam int unsigned R_LSB   = 2;
  localparam int unsigned IMM_MSB = 5;
  localparam int unsigned IMM_LSB = 2;
  localparam int unsigned RD_MSB  = 1;
  localparam int unsigned RD_LSB  = 0;

  typedef enum logic [1:0] {
    OP_LDI   = 2'b00,
    OP_LOAD  = 2'b01,
    OP_STORE = 2'b10,
    OP_STOP  = 2'b11
  } opcode_e;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_EXEC  = 2'd1,
    ST_HALT  = 2'd2
  } state_e;

  typedef struct packed {
    opcode_e            op;
    logic [RIDX_W-1:0]  a;
    logic [RIDX_W-1:0]  r;
    logic [IMM_W-1:0]   imm;
    logic [RIDX_W-1:0]  rd;
  } instr_t;

  // Fields overlap (imm shares bits with a/r); every view is extracted.
  function automatic instr_t decode(input logic [INSTR_W-1:0] w);
    instr_t d;
    d.op  = opcode_e'(w[OP_MSB:OP_LSB]);
    d.a   = w[A_MSB:A_LSB];
    d.r   = w[R_MSB:R_LSB];
    d.imm = w[IMM_MSB:IMM_LSB];
    d.rd  = w[RD_MSB:RD_LSB];
    return d;
  endfunction

endpackage

// File: rtl/regfile4x8.sv
// Four 8-bit registers: one synchronous write port, two combinational read
// ports, synchronous clear, plus a full dump for display/debug.
module regfile4x8
  import cpu_controller_pkg::*;
(
  input  logic              clk,
  input  logic              clear,
  input  logic              we,
  input  logic [RIDX_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [RIDX_W-1:0] raddr0,
  output logic [DATA_W-1:0] rdata0,
  input  logic [RIDX_W-1:0] raddr1,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] reg0,
  output logic [DATA_W-1:0] reg1,
  output logic [DATA_W-1:0] reg2,
  output logic [DATA_W-1:0] reg3
);

  logic [DATA_W-1:0] mem [NREGS];

  always_ff @(posedge clk) begin
    if (clear) begin
      mem <= '{default: '0};
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata0 = mem[raddr0];
  assign rdata1 = mem[raddr1];

  assign reg0 = mem[0];
  assign reg1 = mem[1];
  assign reg2 = mem[2];
  assign reg3 = mem[3];

endmodule

// File: rtl/cpu_controller.sv
// Two-cycle-per-instruction controller: FETCH latches the program word into IR,
// EXEC performs LDI/LOAD/STORE and advances PC; STOP parks the FSM in HALT.
module cpu_controller
  import cpu_controller_pkg::*;
#(
  parameter int unsigned PROG_DEPTH = 32
) (
  input  logic               clk,
  input  logic               clear,
  input  logic               run,
  input  logic [INSTR_W-1:0] instruction,
  output logic [ADDR_W-1:0]  address,
  output logic               halted,
  output logic [DATA_W-1:0]  reg0,
  output logic [DATA_W-1:0]  reg1,
  output logic [DATA_W-1:0]  reg2,
  output logic [DATA_W-1:0]  reg3
);

  localparam int unsigned PC_W = (PROG_DEPTH > 1) ? $clog2(PROG_DEPTH) : 1;
  localparam logic [PC_W-1:0] PC_LAST = PC_W'(PROG_DEPTH - 1);

  state_e             state, state_next;
  logic [PC_W-1:0]    pc, pc_next;
  logic [INSTR_W-1:0] ir, ir_next;
  instr_t             dec;

  logic               rf_we;
  logic [RIDX_W-1:0]  rf_waddr;
  logic [DATA_W-1:0]  rf_wdata;
  logic [DATA_W-1:0]  rf_rdata;
  logic [DATA_W-1:0]  unused_rf_rdata1;

  logic               dm_we;
  logic [DATA_W-1:0]  dmem [DMEM_DEPTH];

  assign dec = decode(ir);

  // FSM, PC and IR registers; clear wins over run and any pending operation
  always_ff @(posedge clk) begin
    if (clear) begin
      state <= ST_FETCH;
      pc    <= '0;
      ir    <= '0;
    end else begin
      state <= state_next;
      pc    <= pc_next;
      ir    <= ir_next;
    end
  end

  // Data memory; STORE address comes from the a field, data from reg[r]
  always_ff @(posedge clk) begin
    if (clear) begin
      dmem <= '{default: '0};
    end else if (dm_we) begin
      dmem[dec.a] <= rf_rdata;
    end
  end

  // Next-state and datapath control; run low leaves every default in place
  always_comb begin
    state_next = state;
    pc_next    = pc;
    ir_next    = ir;
    rf_we      = 1'b0;
    rf_waddr   = dec.rd;
    rf_wdata   = '0;
    dm_we      = 1'b0;

    if (run) begin
      case (state)
        ST_FETCH: begin
          ir_next    = instruction;
          state_next = ST_EXEC;
        end
        ST_EXEC: begin
          state_next = ST_FETCH;
          pc_next    = (pc == PC_LAST) ? '0 : pc + PC_W'(1);
          case (dec.op)
            OP_LDI: begin
              rf_we    = 1'b1;
              rf_waddr = dec.rd;
              rf_wdata = DATA_W'(dec.imm);
            end
            OP_LOAD: begin
              rf_we    = 1'b1;
              rf_waddr = dec.r;
              rf_wdata = dmem[dec.a];
            end
            OP_STORE: begin
              dm_we = 1'b1;
            end
            OP_STOP: begin
              state_next = ST_HALT;
              pc_next    = pc;
            end
            default: ;
          endcase
        end
        ST_HALT: ;
        default: state_next = ST_FETCH;
      endcase
    end
  end

  regfile4x8 u_regfile (
    .clk    (clk),
    .clear  (clear),
    .we     (rf_we),
    .waddr  (rf_waddr),
    .wdata  (rf_wdata),
    .raddr0 (dec.r),
    .rdata0 (rf_rdata),
    .raddr1 (dec.rd),
    .rdata1 (unused_rf_rdata1),
    .reg0   (reg0),
    .reg1   (reg1),
    .reg2   (reg2),
    .reg3   (reg3)
  );

  assign address = ADDR_W'(pc);
  assign halted  = (state == ST_HALT);

endmodule
